vram_arbiter: RTL and testbench

Single-port video RAM arbiter between the VGA scanout path and the CPU bus. It sits between the 640x400 VGA timing generator (320x200 byte address stream, one new byte every 2 pixel clocks) and the external 64 KiB x 8 SRAM. Video fetches get fixed priority during active display. CPU reads and writes are served in the remaining slots through a req/ack handshake, with a starvation guard.

---
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port video SRAM arbiter: scanout fetches win by default, CPU accesses
// take the free slots, and a starvation counter forces a waiting CPU through.
module vram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [15:0] iVidAddr,
  input  logic        iVidStrobe,
  input  logic        iVidBlank,
  output logic [7:0]  oVidData,
  output logic        oVidValid,
  output logic        oVidMiss,
  input  logic        iCpuReq,
  input  logic        iCpuWr,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oCpuData,
  output logic        oCpuAck,
  output logic [15:0] oRamAddr,
  output logic [7:0]  oRamData,
  output logic        oRamWe,
  output logic        oRamOe,
  input  logic [7:0]  iRamData
);

  typedef enum logic [1:0] {
    DONE_NONE,
    DONE_VID,
    DONE_CPU_RD,
    DONE_CPU_WR
  } done_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic        cpu_busy_q, cpu_busy_d;
  done_e       done_q, done_d;
  logic        miss_pend_q, miss_pend_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_oe_q, ram_oe_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        vid_valid_q, vid_valid_d;
  logic        vid_miss_q, vid_miss_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic        cpu_ack_q, cpu_ack_d;

  logic vid_req, cpu_req, cpu_forced, grant_cpu, grant_vid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    vid_req    = iVidStrobe & ~iVidBlank;
    cpu_req    = iCpuReq & ~cpu_busy_q;
    cpu_forced = cpu_req & (starve_q == STARVE_LIM);
    grant_cpu  = cpu_forced | (cpu_req & ~vid_req);
    grant_vid  = vid_req & ~cpu_forced;

    // Completion of the access issued in the previous slot; iRamData is valid now.
    vid_valid_d = (done_q == DONE_VID);
    vid_data_d  = vid_valid_d ? iRamData : vid_data_q;
    cpu_ack_d   = (done_q == DONE_CPU_RD) | (done_q == DONE_CPU_WR);
    cpu_data_d  = (done_q == DONE_CPU_RD) ? iRamData : cpu_data_q;
    vid_miss_d  = miss_pend_q;

    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    ram_oe_d   = 1'b0;
    done_d     = DONE_NONE;

    if (grant_cpu) begin
      ram_addr_d = iCpuAddr;
      if (iCpuWr) begin
        ram_data_d = iCpuData;
        ram_we_d   = 1'b1;
        done_d     = DONE_CPU_WR;
      end else begin
        ram_oe_d = 1'b1;
        done_d   = DONE_CPU_RD;
      end
    end else if (grant_vid) begin
      ram_addr_d = iVidAddr;
      ram_oe_d   = 1'b1;
      done_d     = DONE_VID;
    end

    // The miss is reported alongside the forced CPU access's ack.
    miss_pend_d = cpu_forced & vid_req;
    cpu_busy_d  = grant_cpu;

    starve_d = starve_q;
    if (grant_cpu || !iCpuReq) begin
      starve_d = '0;
    end else if (grant_vid && cpu_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      starve_q    <= '0;
      cpu_busy_q  <= 1'b0;
      done_q      <= DONE_NONE;
      miss_pend_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_miss_q  <= 1'b0;
      cpu_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      cpu_busy_q  <= cpu_busy_d;
      done_q      <= done_d;
      miss_pend_q <= miss_pend_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      vid_miss_q  <= vid_miss_d;
      cpu_data_q  <= cpu_data_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign oVidData  = vid_data_q;
  assign oVidValid = vid_valid_q;
  assign oVidMiss  = vid_miss_q;
  assign oCpuData  = cpu_data_q;
  assign oCpuAck   = cpu_ack_q;
  assign oRamAddr  = ram_addr_q;
  assign oRamData  = ram_data_q;
  assign oRamWe    = ram_we_q;
  assign oRamOe    = ram_oe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: SRAM model plus a slot-level reference model of the
// arbitration rules, directed scenarios and a randomized run.
module tb_vram_arbiter;

  localparam int STARVE_MAX = 4;

  logic        iClk;
  logic        iRst;
  logic [15:0] iVidAddr;
  logic        iVidStrobe;
  logic        iVidBlank;
  logic [7:0]  oVidData;
  logic        oVidValid;
  logic        oVidMiss;
  logic        iCpuReq;
  logic        iCpuWr;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic [7:0]  oCpuData;
  logic        oCpuAck;
  logic [15:0] oRamAddr;
  logic [7:0]  oRamData;
  logic        oRamWe;
  logic        oRamOe;
  logic [7:0]  iRamData;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .iClk(iClk), .iRst(iRst),
    .iVidAddr(iVidAddr), .iVidStrobe(iVidStrobe), .iVidBlank(iVidBlank),
    .oVidData(oVidData), .oVidValid(oVidValid), .oVidMiss(oVidMiss),
    .iCpuReq(iCpuReq), .iCpuWr(iCpuWr), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .oCpuData(oCpuData), .oCpuAck(oCpuAck),
    .oRamAddr(oRamAddr), .oRamData(oRamData), .oRamWe(oRamWe), .oRamOe(oRamOe),
    .iRamData(iRamData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // External SRAM: asynchronous read while OE, write on the edge ending a WE cycle.
  logic [7:0] sram [65536];
  assign iRamData = oRamOe ? sram[oRamAddr] : 8'h00;
  initial begin
    for (int a = 0; a < 65536; a++) sram[a] = init_byte(16'(a));
    forever begin
      @(posedge iClk);
      if (oRamWe) sram[oRamAddr] <= oRamData;
    end
  end

  // Reference model: one arbitration decision per edge, completions one edge later.
  typedef enum int {P_NONE, P_VID, P_RD, P_WR} pend_t;
  logic [7:0]  model_mem [65536];
  pend_t       m_pend;
  logic [15:0] m_pend_addr;
  logic [7:0]  m_pend_data;
  bit          m_miss, m_busy, m_vid_req, m_cpu_req, m_cpu_grant;
  int          m_starve;
  logic [15:0] e_ram_addr;
  logic [7:0]  e_ram_data, e_vid_data, e_cpu_data;
  logic        e_we, e_oe, e_vid_valid, e_vid_miss, e_cpu_ack;

  wire [44:0] dut_o = {oRamAddr, oRamData, oRamWe, oRamOe, oVidData, oVidValid,
                       oVidMiss, oCpuData, oCpuAck};
  wire [44:0] exp_o = {e_ram_addr, e_ram_data, e_we, e_oe, e_vid_data, e_vid_valid,
                       e_vid_miss, e_cpu_data, e_cpu_ack};

  task automatic model_reset();
    m_pend = P_NONE; m_miss = 0; m_busy = 0; m_starve = 0;
    e_ram_addr = '0; e_ram_data = '0; e_vid_data = '0; e_cpu_data = '0;
    e_we = 0; e_oe = 0; e_vid_valid = 0; e_vid_miss = 0; e_cpu_ack = 0;
  endtask

  task automatic model_step();
    e_vid_valid = 0;
    e_cpu_ack   = 0;
    e_vid_miss  = m_miss;
    case (m_pend)
      P_VID: begin e_vid_data = m_pend_data; e_vid_valid = 1; end
      P_RD:  begin e_cpu_data = m_pend_data; e_cpu_ack = 1; end
      P_WR:  begin model_mem[m_pend_addr] = m_pend_data; e_cpu_ack = 1; end
      default: ;
    endcase
    m_vid_req   = iVidStrobe && !iVidBlank;
    m_cpu_req   = iCpuReq && !m_busy;
    m_pend      = P_NONE;
    m_miss      = 0;
    m_cpu_grant = 0;
    e_we        = 0;
    e_oe        = 0;
    if (m_cpu_req && m_starve == STARVE_MAX) begin
      m_cpu_grant = 1;
      m_miss      = m_vid_req;
    end else if (m_vid_req) begin
      e_ram_addr  = iVidAddr;
      e_oe        = 1;
      m_pend      = P_VID;
      m_pend_data = model_mem[iVidAddr];
      if (m_cpu_req && m_starve < STARVE_MAX) m_starve++;
    end else if (m_cpu_req) begin
      m_cpu_grant = 1;
    end
    if (m_cpu_grant) begin
      e_ram_addr = iCpuAddr;
      m_starve   = 0;
      if (iCpuWr) begin
        e_ram_data  = iCpuData;
        e_we        = 1;
        m_pend      = P_WR;
        m_pend_addr = iCpuAddr;
        m_pend_data = iCpuData;
      end else begin
        e_oe        = 1;
        m_pend      = P_RD;
        m_pend_data = model_mem[iCpuAddr];
      end
    end
    if (!iCpuReq) m_starve = 0;
    m_busy = m_cpu_grant;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) model_mem[a] = init_byte(16'(a));
    model_reset();
    forever begin
      @(posedge iClk or posedge iRst);
      if (iRst) model_reset();
      else model_step();
    end
  end

  task automatic cpu_request(input logic wr, input logic [15:0] a, input logic [7:0] d);
    iCpuReq = 1'b1; iCpuWr = wr; iCpuAddr = a; iCpuData = d;
  endtask

  // Lets any outstanding CPU access complete and returns all inputs to idle.
  task automatic settle();
    iVidStrobe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk);
      if (e_cpu_ack) iCpuReq = 1'b0;
    end
    iCpuReq = 1'b0;
  endtask

  task automatic test_reset();
    int acks;
    repeat (2) @(negedge iClk);
    checks++;
    if (dut_o !== '0) begin
      errors++; $display("FAIL reset_init: outputs %h, required 0", dut_o);
    end
    iRst = 1'b0;
    @(negedge iClk);
    cpu_request(1'b0, 16'h0400, 8'h00);
    @(posedge iClk);
    #1;
    checks++;
    if (oRamOe !== 1'b1 || oRamAddr !== 16'h0400) begin
      errors++; $display("FAIL reset_grant: oe %b addr %h, required 1 0400", oRamOe, oRamAddr);
    end
    #1 iRst = 1'b1;
    #1;
    checks++;
    if (dut_o !== '0) begin
      errors++; $display("FAIL reset_async: outputs %h, required 0", dut_o);
    end
    iCpuReq = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      if (oCpuAck) acks++;
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL reset_after cycle %0d: dut %h, model %h", i, dut_o, exp_o);
      end
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL reset_no_ack: %0d acks, required 0", acks);
    end
  endtask

  task automatic test_video_fetch();
    iVidStrobe = 1'b1; iVidBlank = 1'b0; iVidAddr = 16'h1234;
    @(negedge iClk);
    iVidStrobe = 1'b0;
    checks++;
    if (oRamAddr !== 16'h1234 || oRamOe !== 1'b1 || oRamWe !== 1'b0) begin
      errors++; $display("FAIL vid_access: addr %h oe %b we %b, required 1234 1 0",
                         oRamAddr, oRamOe, oRamWe);
    end
    @(negedge iClk);
    checks++;
    if (oVidData !== 8'h5A || oVidValid !== 1'b1) begin
      errors++; $display("FAIL vid_data: data %h valid %b, required 5a 1", oVidData, oVidValid);
    end
    @(negedge iClk);
    checks++;
    if (oVidValid !== 1'b0 || dut_o !== exp_o) begin
      errors++; $display("FAIL vid_pulse: dut %h, model %h", dut_o, exp_o);
    end
  endtask

  task automatic test_cpu_write_read();
    int  we_cycles, acks;
    bit  we_ok, got;
    cpu_request(1'b1, 16'h00FF, 8'hC3);
    we_cycles = 0; acks = 0; we_ok = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge iClk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL write_cycle %0d: dut %h, model %h", i, dut_o, exp_o);
      end
      if (oRamWe) begin
        we_cycles++;
        if (oRamData !== 8'hC3 || oRamAddr !== 16'h00FF) we_ok = 0;
      end
      if (oCpuAck) acks++;
      if (e_cpu_ack) iCpuReq = 1'b0;
    end
    checks++;
    if (we_cycles != 1 || !we_ok || acks != 1) begin
      errors++; $display("FAIL write_shape: we cycles %0d ok %0d acks %0d, required 1 1 1",
                         we_cycles, we_ok, acks);
    end
    cpu_request(1'b0, 16'h00FF, 8'h00);
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge iClk);
      if (oCpuAck) begin
        got = 1;
        checks++;
        if (oCpuData !== 8'hC3) begin
          errors++; $display("FAIL read_back: data %h, required c3", oCpuData);
        end
      end
      if (e_cpu_ack) iCpuReq = 1'b0;
    end
    if (!got) begin
      checks++; errors++; $display("FAIL read_timeout: no ack within 5 edges, required ack");
    end
    settle();
  endtask

  task automatic test_interleave();
    int lat, max_lat, acks, misses;
    cpu_request(1'b0, 16'(32'h0040 + $urandom_range(0, 15)), 8'h00);
    lat = 0; max_lat = 0; acks = 0; misses = 0;
    for (int i = 0; i < 24; i++) begin
      iVidStrobe = (i % 2 == 0); iVidBlank = 1'b0; iVidAddr = 16'(32'h8000 + i);
      @(negedge iClk);
      lat++;
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL interleave cycle %0d: dut %h, model %h", i, dut_o, exp_o);
      end
      if (oVidMiss) misses++;
      if (oCpuAck) begin
        acks++;
        if (lat > max_lat) max_lat = lat;
      end
      if (e_cpu_ack) begin
        cpu_request(1'b0, 16'(32'h0040 + $urandom_range(0, 15)), 8'h00);
        lat = 0;
      end
    end
    checks++;
    if (max_lat < 2 || max_lat > 3 || acks < 6 || misses != 0) begin
      errors++; $display("FAIL interleave_lat: max %0d acks %0d misses %0d, required 2..3 >=6 0",
                         max_lat, acks, misses);
    end
    settle();
  endtask

  task automatic test_starve();
    int  vid_grants, n;
    bit  cpu_seen, done;
    n = 0;
    cpu_request(1'b0, 16'h0100, 8'h00);
    for (int r = 0; r < 2; r++) begin
      vid_grants = 0; cpu_seen = 0; done = 0;
      for (int i = 0; i < 12 && !done; i++) begin
        iVidStrobe = 1'b1; iVidBlank = 1'b0; iVidAddr = 16'(32'h8000 + n);
        n++;
        @(negedge iClk);
        checks++;
        if (dut_o !== exp_o) begin
          errors++; $display("FAIL starve round %0d cycle %0d: dut %h, model %h", r, i, dut_o, exp_o);
        end
        if (oRamOe && oRamAddr == 16'h0100) cpu_seen = 1;
        else if (oRamOe && oRamAddr[15] && !cpu_seen) vid_grants++;
        if (e_cpu_ack) begin
          done = 1;
          checks++;
          if (oCpuAck !== 1'b1 || oVidMiss !== 1'b1) begin
            errors++; $display("FAIL starve_miss round %0d: ack %b miss %b, required 1 1",
                               r, oCpuAck, oVidMiss);
          end
          if (r == 0) cpu_request(1'b0, 16'h0100, 8'h00);
          else iCpuReq = 1'b0;
        end
      end
      checks++;
      if (!done || vid_grants != STARVE_MAX) begin
        errors++; $display("FAIL starve_count round %0d: done %0d video grants %0d, required 1 %0d",
                           r, done, vid_grants, STARVE_MAX);
      end
    end
    settle();
  endtask

  task automatic test_blank_writes();
    int wes, valids, oes, acks;
    wes = 0; valids = 0; oes = 0; acks = 0;
    iVidBlank = 1'b1;
    cpu_request(1'b1, 16'h2000, 8'($urandom));
    for (int i = 0; i < 16; i++) begin
      iVidStrobe = 1'b1; iVidAddr = 16'(32'h9000 + i);
      @(negedge iClk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL blank cycle %0d: dut %h, model %h", i, dut_o, exp_o);
      end
      wes += int'(oRamWe); valids += int'(oVidValid); oes += int'(oRamOe); acks += int'(oCpuAck);
      if (e_cpu_ack) cpu_request(1'b1, 16'(32'h2000 + i), 8'($urandom));
    end
    checks++;
    if (wes != 8 || valids != 0 || oes != 0 || acks != 8) begin
      errors++; $display("FAIL blank_shape: we %0d valid %0d oe %0d acks %0d, required 8 0 0 8",
                         wes, valids, oes, acks);
    end
    iVidBlank = 1'b0;
    settle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      iVidBlank  = ($urandom_range(0, 4) == 0);
      iVidStrobe = 1'($urandom_range(0, 1));
      iVidAddr   = 16'($urandom_range(0, 31));
      if (!iCpuReq && $urandom_range(0, 2) == 0)
        cpu_request(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
      @(negedge iClk);
      checks++;
      if (dut_o !== exp_o) begin
        errors++; $display("FAIL random cycle %0d: dut %h, model %h", i, dut_o, exp_o);
      end
      if (e_cpu_ack) begin
        iCpuReq = 1'b0;
        if ($urandom_range(0, 1) == 1)
          cpu_request(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom));
      end
    end
    settle();
  endtask

  initial begin
    iRst = 1'b1;
    iVidAddr = '0; iVidStrobe = 1'b0; iVidBlank = 1'b0;
    iCpuReq = 1'b0; iCpuWr = 1'b0; iCpuAddr = '0; iCpuData = '0;
    test_reset();
    test_video_fetch();
    test_cpu_write_read();
    test_interleave();
    test_starve();
    test_blank_writes();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
